// File: rtl/frame_buffer_arbiter_if.sv
// Write/read grant channels between capture/display controllers and the frame buffer arbiter.
// The slave modport is the arbiter side; the master modport is the controller side.
interface frame_buffer_arbiter_if #(
    parameter int NUM_BUFFERS = 3,
    parameter int DROP_W      = 16
);
    localparam int ID_W = $clog2(NUM_BUFFERS);

    logic              wr_req;
    logic              wr_done;
    logic              wr_grant;
    logic [ID_W-1:0]   wr_id;
    logic              rd_req;
    logic              rd_done;
    logic              rd_grant;
    logic [ID_W-1:0]   rd_id;
    logic              rd_fresh;
    logic [DROP_W-1:0] dropped;

    modport slave (
        input  wr_req, wr_done, rd_req, rd_done,
        output wr_grant, wr_id, rd_grant, rd_id, rd_fresh, dropped
    );

    modport master (
        output wr_req, wr_done, rd_req, rd_done,
        input  wr_grant, wr_id, rd_grant, rd_id, rd_fresh, dropped
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// N-buffer frame arbiter: writer never blocks (reuses shown buffers or drops stale frames), reader gets newest frame.
// Grants are registered on the edge that samples req; reader waits only when nothing is showable.
module frame_buffer_arbiter #(
    parameter int NUM_BUFFERS = 3,
    parameter int REPEAT_LAST = 1,
    parameter int DROP_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    frame_buffer_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_BUFFERS);
    localparam int SUM_W = DROP_W + 4;
    localparam logic [SUM_W-1:0] DROP_MAX = {4'b0000, {DROP_W{1'b1}}};

    typedef enum logic [2:0] {B_FREE, B_WRITING, B_READY, B_READING, B_SHOWN} buf_state_t;
    typedef enum logic {W_IDLE, W_OWN} w_state_t;
    typedef enum logic {R_IDLE, R_OWN} r_state_t;

    buf_state_t buf_q [NUM_BUFFERS];
    buf_state_t buf_d [NUM_BUFFERS];
    buf_state_t wview [NUM_BUFFERS];
    w_state_t   w_q, w_d;
    r_state_t   r_q, r_d;

    logic [ID_W-1:0]   last_wr_q, last_wr_d, last_rd_q, last_rd_d;
    logic              last_wr_vld_q, last_wr_vld_d, last_rd_vld_q, last_rd_vld_d;
    logic              wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
    logic [ID_W-1:0]   wr_id_q, wr_id_d, rd_id_q, rd_id_d;
    logic              rd_fresh_q, rd_fresh_d;
    logic [DROP_W-1:0] dropped_q, dropped_d;

    logic              rd_take, wr_take;
    logic [ID_W-1:0]   rd_pick, wr_pick;
    logic              free_hit, shown_hit, ready_hit;
    logic [ID_W-1:0]   free_idx, shown_idx, ready_idx;
    logic [3:0]        drop_inc;
    logic [SUM_W-1:0]  drop_sum;

    always_comb begin
        buf_d         = buf_q;
        wview         = buf_q;
        w_d           = w_q;
        r_d           = r_q;
        last_wr_d     = last_wr_q;
        last_wr_vld_d = last_wr_vld_q;
        last_rd_d     = last_rd_q;
        last_rd_vld_d = last_rd_vld_q;
        wr_grant_d    = 1'b0;
        rd_grant_d    = 1'b0;
        wr_id_d       = wr_id_q;
        rd_id_d       = rd_id_q;
        rd_fresh_d    = rd_fresh_q;
        rd_take       = 1'b0;
        rd_pick       = '0;
        wr_take       = 1'b0;
        wr_pick       = '0;
        free_hit      = 1'b0;
        shown_hit     = 1'b0;
        ready_hit     = 1'b0;
        free_idx      = '0;
        shown_idx     = '0;
        ready_idx     = '0;
        drop_inc      = '0;

        if (w_q == W_OWN && bus.wr_done) begin
            buf_d[wr_id_q] = B_READY;
            last_wr_d      = wr_id_q;
            last_wr_vld_d  = 1'b1;
            w_d            = W_IDLE;
        end
        if (r_q == R_OWN && bus.rd_done) begin
            for (int i = 0; i < NUM_BUFFERS; i++)
                if (buf_q[i] == B_SHOWN && ID_W'(i) != rd_id_q) buf_d[i] = B_FREE;
            buf_d[rd_id_q] = B_SHOWN;
            r_d            = R_IDLE;
        end

        // Reader decides first; its claim and its drops shape what the writer may take.
        if (r_q == R_IDLE && bus.rd_req) begin
            if (last_wr_vld_q && buf_q[last_wr_q] == B_READY) begin
                rd_take    = 1'b1;
                rd_pick    = last_wr_q;
                rd_fresh_d = 1'b1;
                for (int i = 0; i < NUM_BUFFERS; i++) begin
                    if (buf_q[i] == B_READY && ID_W'(i) != last_wr_q) begin
                        buf_d[i] = B_FREE;
                        wview[i] = B_FREE;
                        drop_inc = drop_inc + 4'd1;
                    end
                end
            end else if (REPEAT_LAST != 0 && last_rd_vld_q && buf_q[last_rd_q] == B_SHOWN) begin
                rd_take    = 1'b1;
                rd_pick    = last_rd_q;
                rd_fresh_d = 1'b0;
            end
            if (rd_take) begin
                buf_d[rd_pick] = B_READING;
                wview[rd_pick] = B_READING;
                last_rd_d      = rd_pick;
                last_rd_vld_d  = 1'b1;
                rd_id_d        = rd_pick;
                rd_grant_d     = 1'b1;
                r_d            = R_OWN;
            end
        end

        if (w_q == W_IDLE && bus.wr_req) begin
            // Descending scan so the surviving index in each class is the lowest one.
            for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
                if (wview[i] == B_FREE) begin
                    free_hit = 1'b1;
                    free_idx = ID_W'(i);
                end
                if (wview[i] == B_SHOWN && !(last_rd_vld_q && ID_W'(i) == last_rd_q)) begin
                    shown_hit = 1'b1;
                    shown_idx = ID_W'(i);
                end
                if (wview[i] == B_READY && !(last_wr_vld_q && ID_W'(i) == last_wr_q)) begin
                    ready_hit = 1'b1;
                    ready_idx = ID_W'(i);
                end
            end
            if (free_hit) begin
                wr_take = 1'b1;
                wr_pick = free_idx;
            end else if (shown_hit) begin
                wr_take = 1'b1;
                wr_pick = shown_idx;
            end else if (ready_hit) begin
                wr_take  = 1'b1;
                wr_pick  = ready_idx;
                drop_inc = drop_inc + 4'd1;
            end else if (last_wr_vld_q && wview[last_wr_q] == B_READY) begin
                wr_take  = 1'b1;
                wr_pick  = last_wr_q;
                drop_inc = drop_inc + 4'd1;
            end
            if (wr_take) begin
                buf_d[wr_pick] = B_WRITING;
                wr_id_d        = wr_pick;
                wr_grant_d     = 1'b1;
                w_d            = W_OWN;
            end
        end

        drop_sum  = SUM_W'(dropped_q) + SUM_W'(drop_inc);
        dropped_d = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUFFERS; i++) buf_q[i] <= B_FREE;
            w_q           <= W_IDLE;
            r_q           <= R_IDLE;
            last_wr_q     <= '0;
            last_wr_vld_q <= 1'b0;
            last_rd_q     <= '0;
            last_rd_vld_q <= 1'b0;
            wr_grant_q    <= 1'b0;
            rd_grant_q    <= 1'b0;
            wr_id_q       <= '0;
            rd_id_q       <= '0;
            rd_fresh_q    <= 1'b0;
            dropped_q     <= '0;
        end else begin
            buf_q         <= buf_d;
            w_q           <= w_d;
            r_q           <= r_d;
            last_wr_q     <= last_wr_d;
            last_wr_vld_q <= last_wr_vld_d;
            last_rd_q     <= last_rd_d;
            last_rd_vld_q <= last_rd_vld_d;
            wr_grant_q    <= wr_grant_d;
            rd_grant_q    <= rd_grant_d;
            wr_id_q       <= wr_id_d;
            rd_id_q       <= rd_id_d;
            rd_fresh_q    <= rd_fresh_d;
            dropped_q     <= dropped_d;
        end
    end

    assign bus.wr_grant = wr_grant_q;
    assign bus.wr_id    = wr_id_q;
    assign bus.rd_grant = rd_grant_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_fresh = rd_fresh_q;
    assign bus.dropped  = dropped_q;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: three instances (N=3 repeat, N=3 no-repeat, N=2 with a 2-bit drop counter)
// checked every cycle against a queue-based model, plus hand-computed directed expectations.
module tb_frame_buffer_arbiter;
    localparam int NI = 3;
    localparam int NB   [NI] = '{3, 3, 2};
    localparam int REP  [NI] = '{1, 0, 1};
    localparam int DMAX [NI] = '{65535, 65535, 3};
    localparam int FREE = 0, WRITING = 1, READY = 2, READING = 3, SHOWN = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic        wr_req_a [NI];
    logic        wr_done_a[NI];
    logic        rd_req_a [NI];
    logic        rd_done_a[NI];
    logic        wg_a     [NI];
    logic        rg_a     [NI];
    logic        rf_a     [NI];
    logic [2:0]  wid_a    [NI];
    logic [2:0]  rid_a    [NI];
    logic [15:0] drp_a    [NI];

    frame_buffer_arbiter_if #(.NUM_BUFFERS(3), .DROP_W(16)) if0 ();
    frame_buffer_arbiter_if #(.NUM_BUFFERS(3), .DROP_W(16)) if1 ();
    frame_buffer_arbiter_if #(.NUM_BUFFERS(2), .DROP_W(2))  if2 ();

    frame_buffer_arbiter #(.NUM_BUFFERS(3), .REPEAT_LAST(1), .DROP_W(16)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    frame_buffer_arbiter #(.NUM_BUFFERS(3), .REPEAT_LAST(0), .DROP_W(16)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    frame_buffer_arbiter #(.NUM_BUFFERS(2), .REPEAT_LAST(1), .DROP_W(2))  dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    assign if0.wr_req = wr_req_a[0];  assign if0.wr_done = wr_done_a[0];
    assign if0.rd_req = rd_req_a[0];  assign if0.rd_done = rd_done_a[0];
    assign if1.wr_req = wr_req_a[1];  assign if1.wr_done = wr_done_a[1];
    assign if1.rd_req = rd_req_a[1];  assign if1.rd_done = rd_done_a[1];
    assign if2.wr_req = wr_req_a[2];  assign if2.wr_done = wr_done_a[2];
    assign if2.rd_req = rd_req_a[2];  assign if2.rd_done = rd_done_a[2];

    always_comb begin
        wg_a[0] = if0.wr_grant; rg_a[0] = if0.rd_grant; rf_a[0] = if0.rd_fresh;
        wid_a[0] = 3'(if0.wr_id); rid_a[0] = 3'(if0.rd_id); drp_a[0] = if0.dropped;
        wg_a[1] = if1.wr_grant; rg_a[1] = if1.rd_grant; rf_a[1] = if1.rd_fresh;
        wid_a[1] = 3'(if1.wr_id); rid_a[1] = 3'(if1.rd_id); drp_a[1] = if1.dropped;
        wg_a[2] = if2.wr_grant; rg_a[2] = if2.rd_grant; rf_a[2] = if2.rd_fresh;
        wid_a[2] = 3'(if2.wr_id); rid_a[2] = 3'(if2.rd_id); drp_a[2] = 16'(if2.dropped);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-instance buffer states, owners and last pointers.
    int  bs     [NI][8];
    int  lw     [NI], lr[NI], wid_m[NI], rid_m[NI], drop_m[NI];
    bit  lwv    [NI], lrv[NI], wown[NI], rown[NI], wg_m[NI], rg_m[NI], rf_m[NI];

    task automatic model_step(int k);
        int pre[8];
        int view[8];
        int fq[$];
        int sq[$];
        int rq[$];
        int claim, drops, pick, lw0, lr0;
        bit lwv0, lrv0, wown0, rown0, fresh;
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) bs[k][i] = FREE;
            lw[k] = 0; lr[k] = 0; lwv[k] = 0; lrv[k] = 0; wown[k] = 0; rown[k] = 0;
            wid_m[k] = 0; rid_m[k] = 0; drop_m[k] = 0; wg_m[k] = 0; rg_m[k] = 0; rf_m[k] = 0;
            return;
        end
        pre = bs[k];
        lw0 = lw[k]; lwv0 = lwv[k]; lr0 = lr[k]; lrv0 = lrv[k];
        wown0 = wown[k]; rown0 = rown[k];
        wg_m[k] = 0; rg_m[k] = 0; drops = 0; claim = -1; fresh = 0;
        if (wown0 && wr_done_a[k]) begin
            bs[k][wid_m[k]] = READY; lw[k] = wid_m[k]; lwv[k] = 1; wown[k] = 0;
        end
        if (rown0 && rd_done_a[k]) begin
            for (int i = 0; i < NB[k]; i++) if (pre[i] == SHOWN && i != rid_m[k]) bs[k][i] = FREE;
            bs[k][rid_m[k]] = SHOWN; rown[k] = 0;
        end
        view = pre;
        if (!rown0 && rd_req_a[k]) begin
            if (lwv0 && pre[lw0] == READY) begin
                claim = lw0; fresh = 1;
                for (int i = 0; i < NB[k]; i++)
                    if (pre[i] == READY && i != lw0) begin bs[k][i] = FREE; view[i] = FREE; drops++; end
            end else if (REP[k] != 0 && lrv0 && pre[lr0] == SHOWN) begin
                claim = lr0; fresh = 0;
            end
            if (claim >= 0) begin
                bs[k][claim] = READING; view[claim] = READING;
                lr[k] = claim; lrv[k] = 1; rown[k] = 1; rid_m[k] = claim; rg_m[k] = 1; rf_m[k] = fresh;
            end
        end
        if (!wown0 && wr_req_a[k]) begin
            for (int i = 0; i < NB[k]; i++) begin
                if (view[i] == FREE) fq.push_back(i);
                if (view[i] == SHOWN && !(lrv0 && i == lr0)) sq.push_back(i);
                if (view[i] == READY && !(lwv0 && i == lw0)) rq.push_back(i);
            end
            pick = -1;
            if (fq.size() > 0) pick = fq[0];
            else if (sq.size() > 0) pick = sq[0];
            else if (rq.size() > 0) begin pick = rq[0]; drops++; end
            else if (lwv0 && view[lw0] == READY) begin pick = lw0; drops++; end
            if (pick >= 0) begin
                bs[k][pick] = WRITING; wid_m[k] = pick; wown[k] = 1; wg_m[k] = 1;
            end
        end
        drop_m[k] = (drop_m[k] + drops > DMAX[k]) ? DMAX[k] : drop_m[k] + drops;
    endtask

    initial begin : compare
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) model_step(k);
            #1;
            for (int k = 0; k < NI; k++) begin
                check($sformatf("cyc_wr_grant[%0d]", k), int'(wg_a[k]), int'(wg_m[k]));
                check($sformatf("cyc_rd_grant[%0d]", k), int'(rg_a[k]), int'(rg_m[k]));
                check($sformatf("cyc_dropped[%0d]", k), int'(drp_a[k]), drop_m[k]);
                if (wown[k] || !reset_n) check($sformatf("cyc_wr_id[%0d]", k), int'(wid_a[k]), wid_m[k]);
                if (rown[k] || !reset_n) check($sformatf("cyc_rd_id[%0d]", k), int'(rid_a[k]), rid_m[k]);
                if (rg_m[k] || !reset_n) check($sformatf("cyc_rd_fresh[%0d]", k), int'(rf_a[k]), int'(rf_m[k]));
            end
        end
    end

    task automatic wr_get(int k, output int id);
        bit got = 0;
        wr_req_a[k] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = wg_a[k]; end
        wr_req_a[k] = 1'b0;
        check($sformatf("wr_grant_seen[%0d]", k), int'(got), 1);
        id = int'(wid_a[k]);
    endtask

    task automatic rd_get(int k, int budget, output bit got, output int id, output int fresh);
        got = 0;
        rd_req_a[k] = 1'b1;
        for (int c = 0; c < budget && !got; c++) begin @(negedge clk); got = rg_a[k]; end
        rd_req_a[k] = 1'b0;
        id = int'(rid_a[k]);
        fresh = int'(rf_a[k]);
    endtask

    task automatic pulse_done(int k, bit w, bit r);
        wr_done_a[k] = w; rd_done_a[k] = r;
        @(negedge clk);
        wr_done_a[k] = 1'b0; rd_done_a[k] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : stim
        int id, fresh;
        bit got, gw, gr;
        checks = 0; failures = 0;
        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            wr_req_a[k] = 0; wr_done_a[k] = 0; rd_req_a[k] = 0; rd_done_a[k] = 0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_wr_grant[%0d]", k), int'(wg_a[k]), 0);
            check($sformatf("reset_dropped[%0d]", k), int'(drp_a[k]), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Ping-pong on N=3
        wr_get(0, id); check("pp_wr_id0", id, 0);
        pulse_done(0, 1, 0);
        rd_get(0, 20, got, id, fresh);
        check("pp_rd_grant", int'(got), 1); check("pp_rd_id", id, 0); check("pp_rd_fresh", fresh, 1);
        wr_get(0, id); check("pp_wr_id1", id, 1); check("pp_dropped", int'(drp_a[0]), 0);
        pulse_done(0, 1, 1);

        // Writer outruns reader
        do_reset();
        for (int f = 0; f < 4; f++) begin
            wr_get(0, id);
            check($sformatf("outrun_wr_id%0d", f), id, (f == 3) ? 0 : f);
            if (f == 3) check("outrun_dropped_4th", int'(drp_a[0]), 1);
            pulse_done(0, 1, 0);
        end
        rd_get(0, 20, got, id, fresh);
        check("outrun_rd_id", id, 0); check("outrun_rd_fresh", fresh, 1); check("outrun_dropped", int'(drp_a[0]), 3);
        pulse_done(0, 0, 1);

        // Repeat last shown frame
        rd_get(0, 20, got, id, fresh);
        check("repeat_grant", int'(got), 1); check("repeat_rd_id", id, 0); check("repeat_fresh", fresh, 0);
        pulse_done(0, 0, 1);
        wr_get(1, id); pulse_done(1, 1, 0);
        rd_get(1, 20, got, id, fresh); check("norep_first_fresh", fresh, 1); pulse_done(1, 0, 1);
        rd_get(1, 20, got, id, fresh); check("norep_no_grant", int'(got), 0);

        // Simultaneous reader/writer selection with buf1 READY
        wr_get(0, id); check("sim_setup_wr_id", id, 1);
        pulse_done(0, 1, 0);
        wr_req_a[0] = 1'b1; rd_req_a[0] = 1'b1; gw = 0; gr = 0;
        for (int c = 0; c < 20 && !(gw || gr); c++) begin @(negedge clk); gw = wg_a[0]; gr = rg_a[0]; end
        wr_req_a[0] = 1'b0; rd_req_a[0] = 1'b0;
        check("sim_wr_grant", int'(gw), 1); check("sim_rd_grant", int'(gr), 1);
        check("sim_rd_id", int'(rid_a[0]), 1); check("sim_wr_id", int'(wid_a[0]), 2);
        pulse_done(0, 1, 1);

        // wr_done and rd_req on the same edge: reader takes the older frame
        wr_get(0, id); check("wd_rq_wr_id", id, 0);
        wr_done_a[0] = 1'b1; rd_req_a[0] = 1'b1;
        @(negedge clk);
        wr_done_a[0] = 1'b0; rd_req_a[0] = 1'b0;
        check("wd_rq_rd_grant", int'(rg_a[0]), 1); check("wd_rq_rd_id", int'(rid_a[0]), 2);
        check("wd_rq_dropped", int'(drp_a[0]), 3);
        pulse_done(0, 0, 1);
        rd_get(0, 20, got, id, fresh); check("wd_rq_next_rd_id", id, 0); check("wd_rq_next_fresh", fresh, 1);
        pulse_done(0, 0, 1);

        // N=2 stress with reader holding buf0; 2-bit drop counter saturates
        wr_get(2, id); check("n2_first_wr_id", id, 0);
        pulse_done(2, 1, 0);
        rd_get(2, 20, got, id, fresh); check("n2_rd_id", id, 0);
        for (int i = 0; i < 5; i++) begin
            wr_get(2, id);
            check($sformatf("n2_loop_wr_id%0d", i), id, 1);
            check($sformatf("n2_loop_dropped%0d", i), int'(drp_a[2]), (i > 3) ? 3 : i);
            pulse_done(2, 1, 0);
        end

        // Async reset while both channels own buffers
        wr_get(0, id); pulse_done(0, 1, 0);
        rd_get(0, 20, got, id, fresh); check("ar_rd_id", id, 1); check("ar_rd_fresh", fresh, 1);
        wr_get(0, id); check("ar_wr_id", id, 2);
        #2 reset_n = 1'b0;
        #1;
        check("ar_wr_grant", int'(wg_a[0]), 0); check("ar_rd_grant", int'(rg_a[0]), 0);
        check("ar_wr_id_zero", int'(wid_a[0]), 0); check("ar_rd_id_zero", int'(rid_a[0]), 0);
        check("ar_rd_fresh_zero", int'(rf_a[0]), 0); check("ar_dropped0", int'(drp_a[0]), 0);
        check("ar_dropped2", int'(drp_a[2]), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wr_get(0, id); check("post_reset_wr_id", id, 0);
        wr_get(2, id); check("post_reset_n2_wr_id", id, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected bench completion");
        $fatal(1, "time limit");
    end
endmodule
